csr_trap_file: RTL and testbench
================================

CSR_TRAP_FILE -- requirements
Module: csr_trap_file

Interface
REQ-001 SHALL have parameter HART_ID, default 0, value returned by mhartid (0xF14).
REQ-002 SHALL have parameter NUM_HPM, default 4, range 1..29, count of mhpmcounter3.. (0xB03..) and event inputs.
REQ-003 SHALL have parameter MTVEC_RESET, default 64'h0, reset value of mtvec.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: csr_valid  in  1  CSR instruction; csr_op  in  2  01 RW / 10 RS / 11 RC / 00 none; csr_addr  in  12  address; csr_wdata  in  64  operand.
REQ-006 SHALL have ports: csr_rdata  out  64  old value; csr_illegal  out  1  access illegal.
REQ-007 SHALL have ports: trap_valid  in  1  take trap; trap_cause  in  64; trap_pc  in  64; trap_tval  in  64; mret  in  1.
REQ-008 SHALL have ports: instret  in  1  instruction retired; hpm_event  in  NUM_HPM  per-counter increment; irq_ext  in  1; irq_timer  in  1.
REQ-009 SHALL have ports: trap_vector  out  64; epc  out  64  = mepc; priv  out  2; irq_pending  out  1.

Function
REQ-010 SHALL implement mstatus, mtvec, mip, mie, mscratch, mepc, mcause, mtval, mcycle (0xB00), minstret (0xB02), mhartid, satp, mhpmcounter3..(2+NUM_HPM); other addresses illegal.
REQ-011 SHALL drive csr_rdata combinationally from csr_addr in the same cycle; 0 when illegal.
REQ-012 SHALL assert csr_illegal when csr_valid and (unimplemented address, or priv < csr_addr[9:8], or csr_addr[11:10]==11 with a write effect).
REQ-013 SHALL treat RW as always writing; RS/RC write old|wdata / old&~wdata only when csr_wdata != 0.
REQ-014 SHALL apply writes at the next clk edge; mstatus keeps only MIE(3), MPIE(7), MPP(12:11); mtvec bit1 forced 0; mip software-read-only.
REQ-015 SHALL apply no state change for illegal accesses.
REQ-016 SHALL on trap_valid: mepc<=trap_pc with bits[1:0]=0, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0, MPP<=priv, priv<=11.
REQ-017 SHALL drive trap_vector = {mtvec[63:2],2'b00}, plus 4*trap_cause[5:0] when mtvec[0]=1 and trap_cause[63]=1.
REQ-018 SHALL on mret (no trap_valid): priv<=MPP, MIE<=MPIE, MPIE<=1, MPP<=00.
REQ-019 SHALL prioritise trap_valid > mret > CSR write in one cycle; lower-priority action discarded.
REQ-020 SHALL register irq_ext/irq_timer into mip.MEIP(11)/MTIP(7) every cycle.
REQ-021 SHALL drive irq_pending = |(mip & mie & 0x880) & (MIE | priv != 11), from registered state.
REQ-022 SHALL increment mcycle every cycle, minstret when instret, counter i when hpm_event[i]; a same-cycle CSR write to a counter wins over its increment.
REQ-023 SHALL wrap all counters modulo 2^64.

Reset
REQ-024 SHALL on reset clear all CSRs to 0 except mtvec=MTVEC_RESET, set priv=11; reset wins over all inputs.
REQ-025 SHALL after reset show csr_illegal=0, irq_pending=0, epc=0, priv=11, trap_vector=MTVEC_RESET with bits[1:0] cleared.
REQ-026 SHALL discard any trap, mret or write coincident with reset.

Configuration
REQ-027 SHALL compile mhpmcounter3.. and hpm_event use only when CSR_HPM_EN is defined.
REQ-028 SHALL, without CSR_HPM_EN, keep hpm_event port, ignore it, and return 0 with csr_illegal=0 for 0xB03..0xB1F (writes ignored).

Verification
REQ-029 SHALL cover: RW mscratch 0xDEAD, RS 0x0F0, RC 0x00F -> reads 0xDEAD, then 0xDEAD|0xF0, then &~0xF.
REQ-030 SHALL cover: mtvec=0x8000_0001, trap cause=1<<63|7, pc=0x1002 -> trap_vector=0x8000_001C, mepc=0x1000, MIE 1->0, MPIE=1.
REQ-031 SHALL cover: MPP=00 then mret -> priv=00, MIE=MPIE; read of 0x300 at priv 00 -> csr_illegal=1, no write.
REQ-032 SHALL cover: trap_valid, mret and mscratch write same cycle -> only trap effects, mscratch unchanged.
REQ-033 SHALL cover: write mcycle=0xFFFF_FFFF_FFFF_FFFF -> next cycle 0xFFFF..FF, following cycle 0 (wrap).
REQ-034 SHALL cover: mie=0x80, MIE=1, irq_timer=1 -> irq_pending=1 one cycle later; reset mid-sequence -> irq_pending=0, priv=11.

Source files
------------

// File: rtl/csr_trap_file.sv
// csr_trap_file: machine-mode CSR file with trap entry, mret, interrupts and counters.
// Define CSR_HPM_EN to build mhpmcounter3.. and use hpm_event.
module csr_trap_file #(
  parameter logic [63:0] HART_ID = 64'd0,
  parameter int NUM_HPM = 4,
  parameter logic [63:0] MTVEC_RESET = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_valid,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [63:0]        csr_wdata,
  output logic [63:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               trap_valid,
  input  logic [63:0]        trap_cause,
  input  logic [63:0]        trap_pc,
  input  logic [63:0]        trap_tval,
  input  logic               mret,
  input  logic               instret,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic               irq_ext,
  input  logic               irq_timer,
  output logic [63:0]        trap_vector,
  output logic [63:0]        epc,
  output logic [1:0]         priv,
  output logic               irq_pending
);
  logic st_mie, st_mpie;
  logic [1:0] st_mpp;
  logic [63:0] mtvec, mie_r, mscratch, mepc, mcause, mtval, mcycle, minstret, satp;
  logic meip, mtip;
  logic [63:0] mstatus, mip, rd, wval;
  logic hit, weff, we;
`ifdef CSR_HPM_EN
  logic [63:0] hpm [NUM_HPM];
`else
  logic unused_hpm;
  assign unused_hpm = ^hpm_event;
`endif
  assign mstatus = 64'({st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0});
  assign mip = 64'({meip, 3'b0, mtip, 7'b0});
  always_comb begin
    hit = 1'b1;
    rd = '0;
    case (csr_addr)
      12'h300: rd = mstatus;
      12'h304: rd = mie_r;
      12'h305: rd = mtvec;
      12'h340: rd = mscratch;
      12'h341: rd = mepc;
      12'h342: rd = mcause;
      12'h343: rd = mtval;
      12'h344: rd = mip;
      12'hB00: rd = mcycle;
      12'hB02: rd = minstret;
      12'hF14: rd = HART_ID;
      12'h180: rd = satp;
      default: hit = 1'b0;
    endcase
`ifdef CSR_HPM_EN
    for (int i = 0; i < NUM_HPM; i++)
      if (csr_addr == 12'(12'hB03 + i)) begin
        hit = 1'b1;
        rd = hpm[i];
      end
`else
    if (csr_addr[11:5] == 7'h58 && csr_addr[4:0] >= 5'd3) hit = 1'b1;
`endif
  end
  // RS/RC with a zero operand are pure reads, so they may touch read-only CSRs
  assign weff = csr_op == 2'b01 || (csr_op[1] && csr_wdata != '0);
  assign csr_illegal = csr_valid && (!hit || priv < csr_addr[9:8] || (csr_addr[11:10] == 2'b11 && weff));
  assign csr_rdata = csr_illegal ? '0 : rd;
  assign wval = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? rd | csr_wdata : rd & ~csr_wdata;
  assign we = csr_valid && !csr_illegal && weff && !trap_valid && !mret;
  assign trap_vector = {mtvec[63:2], 2'b00} + ((mtvec[0] && trap_cause[63]) ? {56'b0, trap_cause[5:0], 2'b00} : 64'h0);
  assign epc = mepc;
  assign irq_pending = |(mip & mie_r & 64'h880) && (st_mie || priv != 2'b11);
  always_ff @(posedge clk) begin
    if (reset) begin
      st_mie <= 1'b0;
      st_mpie <= 1'b0;
      st_mpp <= 2'b00;
      priv <= 2'b11;
      mtvec <= MTVEC_RESET;
      mie_r <= '0;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      mtval <= '0;
      mcycle <= '0;
      minstret <= '0;
      satp <= '0;
      meip <= 1'b0;
      mtip <= 1'b0;
    end else begin
      meip <= irq_ext;
      mtip <= irq_timer;
      mcycle <= (we && csr_addr == 12'hB00) ? wval : mcycle + 64'd1;
      minstret <= (we && csr_addr == 12'hB02) ? wval : minstret + 64'(instret);
      if (trap_valid) begin
        mepc <= {trap_pc[63:2], 2'b00};
        mcause <= trap_cause;
        mtval <= trap_tval;
        st_mpie <= st_mie;
        st_mie <= 1'b0;
        st_mpp <= priv;
        priv <= 2'b11;
      end else if (mret) begin
        priv <= st_mpp;
        st_mie <= st_mpie;
        st_mpie <= 1'b1;
        st_mpp <= 2'b00;
      end else if (we) begin
        case (csr_addr)
          12'h300: begin
            st_mie <= wval[3];
            st_mpie <= wval[7];
            st_mpp <= wval[12:11];
          end
          12'h304: mie_r <= wval;
          12'h305: mtvec <= {wval[63:2], 1'b0, wval[0]};
          12'h340: mscratch <= wval;
          12'h341: mepc <= wval;
          12'h342: mcause <= wval;
          12'h343: mtval <= wval;
          12'h180: satp <= wval;
          default: ;
        endcase
      end
    end
  end
`ifdef CSR_HPM_EN
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_HPM; i++)
      hpm[i] <= reset ? '0 : (we && csr_addr == 12'(12'hB03 + i)) ? wval : hpm[i] + 64'(hpm_event[i]);
`endif
endmodule

// File: tb/tb_csr_trap_file.sv
// tb_csr_trap_file: directed and random checks of csr_trap_file against a flat CSR-array model.
module tb_csr_trap_file;
  localparam logic [63:0] HID = 64'd5;
  localparam logic [63:0] MTR = 64'h8000_0100;
  localparam int NH = 4;
`ifdef CSR_HPM_EN
  localparam bit HPM_ON = 1'b1;
`else
  localparam bit HPM_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic csr_valid;
  logic [1:0] csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata;
  logic csr_illegal;
  logic trap_valid, mret;
  logic [63:0] trap_cause, trap_pc, trap_tval;
  logic instret;
  logic [NH-1:0] hpm_event;
  logic irq_ext, irq_timer;
  logic [63:0] trap_vector, epc;
  logic [1:0] priv;
  logic irq_pending;
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] m [4096];
  logic [1:0] mp;
  logic [11:0] al [16];

  always #5 clk = ~clk;

  csr_trap_file #(.HART_ID(HID), .NUM_HPM(NH), .MTVEC_RESET(MTR)) dut (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret(mret), .instret(instret), .hpm_event(hpm_event), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .trap_vector(trap_vector), .epc(epc), .priv(priv), .irq_pending(irq_pending)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_hpm(logic [11:0] a);
    return int'(a) >= 'hB03 && int'(a) < (HPM_ON ? 'hB03 + NH : 'hB20);
  endfunction

  function automatic bit impl(logic [11:0] a);
    return (a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                      12'hB00, 12'hB02, 12'hF14, 12'h180}) || is_hpm(a);
  endfunction

  function automatic bit writable(logic [11:0] a);
    return !(a inside {12'h344, 12'hF14}) && !(is_hpm(a) && !HPM_ON);
  endfunction

  function automatic bit weff();
    return csr_op == 2'b01 || (csr_op[1] && csr_wdata != 64'h0);
  endfunction

  function automatic bit exp_ill();
    return csr_valid && (!impl(csr_addr) || mp < csr_addr[9:8] || (csr_addr[11:10] == 2'b11 && weff()));
  endfunction

  function automatic logic [63:0] cur(logic [11:0] a);
    return a == 12'hF14 ? HID : m[a];
  endfunction

  function automatic logic [63:0] exp_vec();
    return (m[12'h305] & ~64'h3) + ((m[12'h305][0] && trap_cause[63]) ? {56'b0, trap_cause[5:0], 2'b00} : 64'h0);
  endfunction

  function automatic bit exp_irq();
    return ((m[12'h344] & m[12'h304] & 64'h880) != 64'h0) && (m[12'h300][3] || mp != 2'b11);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) m[i] = '0;
    m[12'h305] = MTR;
    mp = 2'b11;
  endtask

  task automatic model_step();
    logic [63:0] old, wv, st;
    logic [11:0] a;
    bit wen;
    if (reset) begin
      model_reset();
      return;
    end
    a = csr_addr;
    old = cur(a);
    st = m[12'h300];
    wv = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? old | csr_wdata : old & ~csr_wdata;
    wen = csr_valid && !exp_ill() && weff() && !trap_valid && !mret;
    m[12'hB00] += 64'd1;
    m[12'hB02] += 64'(instret);
    if (HPM_ON) for (int i = 0; i < NH; i++) m[12'hB03 + i] += 64'(hpm_event[i]);
    if (trap_valid) begin
      m[12'h341] = trap_pc & ~64'h3;
      m[12'h342] = trap_cause;
      m[12'h343] = trap_tval;
      m[12'h300] = {51'b0, mp, 3'b0, st[3], 7'b0};
      mp = 2'b11;
    end else if (mret) begin
      mp = st[12:11];
      m[12'h300] = {56'b0, 1'b1, 3'b0, st[7], 3'b0};
    end else if (wen && writable(a))
      m[a] = a == 12'h300 ? wv & 64'h1888 : a == 12'h305 ? wv & ~64'h2 : wv;
    m[12'h344] = {52'b0, irq_ext, 3'b0, irq_timer, 7'b0};
  endtask

  task automatic tick();
    #1;
    chk("rdata", csr_rdata, exp_ill() ? 64'h0 : cur(csr_addr));
    chk("illegal", 64'(csr_illegal), 64'(exp_ill()));
    chk("trap_vector", trap_vector, exp_vec());
    chk("epc", epc, m[12'h341]);
    chk("priv", 64'(priv), 64'(mp));
    chk("irq_pending", 64'(irq_pending), 64'(exp_irq()));
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr(bit v, logic [1:0] op, logic [11:0] a, logic [63:0] d);
    csr_valid = v;
    csr_op = op;
    csr_addr = a;
    csr_wdata = d;
  endtask

  task automatic idle();
    csr(1'b0, 2'b00, 12'h0, 64'h0);
    trap_valid = 1'b0;
    mret = 1'b0;
    trap_cause = '0;
    trap_pc = '0;
    trap_tval = '0;
    instret = 1'b0;
    hpm_event = '0;
    irq_ext = 1'b0;
    irq_timer = 1'b0;
  endtask

  initial begin
    al = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
           12'hB00, 12'hB02, 12'hF14, 12'h180, 12'hB03, 12'hB05, 12'h7C0, 12'h301};
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_priv", 64'(priv), 64'd3);
    chk("rst_epc", epc, 64'h0);
    chk("rst_irq", 64'(irq_pending), 64'h0);
    chk("rst_illegal", 64'(csr_illegal), 64'h0);
    chk("rst_vector", trap_vector, 64'h8000_0100);
    tick();
    // read-modify-write sequence on mscratch
    csr(1, 2'b01, 12'h340, 64'hDEAD);
    tick();
    csr(1, 2'b10, 12'h340, 64'h0F0);
    #1 chk("rs_old", csr_rdata, 64'hDEAD);
    tick();
    csr(1, 2'b11, 12'h340, 64'h00F);
    #1 chk("rs_new", csr_rdata, 64'hDEFD);
    tick();
    csr(1, 2'b00, 12'h340, 64'h0);
    #1 chk("rc_new", csr_rdata, 64'hDEF0);
    tick();
    csr(1, 2'b10, 12'hF14, 64'h0);
    #1 chk("hartid", csr_rdata, 64'd5);
    chk("hartid_ill", 64'(csr_illegal), 64'h0);
    tick();
    csr(1, 2'b01, 12'hF14, 64'h1);
    #1 chk("hartid_wr_ill", 64'(csr_illegal), 64'h1);
    tick();
    csr(1, 2'b00, 12'h7C0, 64'h0);
    #1 chk("unimpl_ill", 64'(csr_illegal), 64'h1);
    tick();
    csr(1, 2'b01, 12'hB05, 64'h123);
    #1 chk("hpm_wr_ill", 64'(csr_illegal), 64'h0);
    tick();
    csr(1, 2'b00, 12'hB05, 64'h0);
    #1 chk("hpm_rd", csr_rdata, HPM_ON ? 64'h123 : 64'h0);
    tick();
    // vectored trap entry
    csr(1, 2'b01, 12'h305, 64'h8000_0001);
    tick();
    csr(1, 2'b01, 12'h300, 64'h8);
    tick();
    idle();
    trap_valid = 1'b1;
    trap_cause = 64'h8000_0000_0000_0007;
    trap_pc = 64'h1002;
    trap_tval = 64'h55;
    #1 chk("vec_trap", trap_vector, 64'h8000_001C);
    tick();
    idle();
    csr(1, 2'b00, 12'h300, 64'h0);
    #1 chk("trap_epc", epc, 64'h1000);
    chk("trap_mstatus", csr_rdata, 64'h1880);
    tick();
    // drop to user mode via mret, then an illegal access
    csr(1, 2'b11, 12'h300, 64'h1800);
    tick();
    idle();
    mret = 1'b1;
    tick();
    idle();
    #1 chk("mret_priv", 64'(priv), 64'd0);
    csr(1, 2'b01, 12'h300, 64'h1234);
    #1 chk("user_ill", 64'(csr_illegal), 64'h1);
    chk("user_rdata", csr_rdata, 64'h0);
    tick();
    idle();
    trap_valid = 1'b1;
    trap_pc = 64'h2000;
    tick();
    idle();
    csr(1, 2'b00, 12'h300, 64'h0);
    #1 chk("no_write_mstatus", csr_rdata, 64'h80);
    tick();
    // trap beats mret beats CSR write
    idle();
    trap_valid = 1'b1;
    mret = 1'b1;
    trap_cause = 64'h2;
    trap_pc = 64'h3004;
    csr(1, 2'b01, 12'h340, 64'h1111);
    tick();
    idle();
    csr(1, 2'b00, 12'h340, 64'h0);
    #1 chk("prio_mscratch", csr_rdata, 64'hDEF0);
    chk("prio_epc", epc, 64'h3004);
    chk("prio_priv", 64'(priv), 64'd3);
    tick();
    // mcycle wrap
    csr(1, 2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    csr(1, 2'b00, 12'hB00, 64'h0);
    #1 chk("mcycle_max", csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    #1 chk("mcycle_wrap", csr_rdata, 64'h0);
    tick();
    // timer interrupt, then reset mid-sequence
    csr(1, 2'b01, 12'h304, 64'h80);
    tick();
    csr(1, 2'b10, 12'h300, 64'h8);
    tick();
    idle();
    irq_timer = 1'b1;
    #1 chk("irq_before", 64'(irq_pending), 64'h0);
    tick();
    #1 chk("irq_after", 64'(irq_pending), 64'h1);
    reset = 1'b1;
    trap_valid = 1'b1;
    tick();
    reset = 1'b0;
    trap_valid = 1'b0;
    #1 chk("irq_reset", 64'(irq_pending), 64'h0);
    chk("priv_reset", 64'(priv), 64'd3);
    irq_timer = 1'b0;
    tick();
    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      csr_valid = $urandom_range(0, 3) != 0;
      csr_op = 2'($urandom);
      csr_addr = al[$urandom_range(0, 15)];
      csr_wdata = $urandom_range(0, 3) == 0 ? 64'h0 : {$urandom, $urandom};
      trap_valid = $urandom_range(0, 9) == 0;
      mret = $urandom_range(0, 9) == 0;
      trap_cause = {$urandom, $urandom};
      trap_pc = {$urandom, $urandom};
      trap_tval = {$urandom, $urandom};
      instret = 1'($urandom);
      hpm_event = NH'($urandom);
      irq_ext = 1'($urandom);
      irq_timer = 1'($urandom);
      reset = $urandom_range(0, 63) == 0;
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
